// File: rtl/im_loader.sv
// im_loader: boot-time program loader for the SISC core.
// Accepts a byte stream (16-bit big-endian length, then big-endian 32-bit
// words), writes each word into instruction memory at consecutive addresses
// from BASE_ADDR and holds the core in reset until the load completes.
module im_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        im_we,
    output logic [15:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_rst_f,
    output logic        loading,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);

    // Idle counter must be able to hold TIMEOUT itself.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    // 17 bits so MAX_WORDS = 65536 is representable.
    localparam logic [16:0] MAX_WORDS_C = 17'(MAX_WORDS);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_HI = 3'd1;
    localparam logic [2:0] ST_LEN_LO = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_FLUSH  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [15:0]   len_q, len_d;          // program length in words
    logic [1:0]    byte_idx_q, byte_idx_d; // position within current word
    logic [23:0]   shift_q, shift_d;      // first three bytes of current word
    logic [31:0]   wdata_q, wdata_d;      // word presented on im_wdata
    logic          we_q, we_d;            // one-cycle write strobe
    logic [15:0]   words_q, words_d;      // words actually written
    logic [15:0]   cap_q, cap_d;          // words fully assembled so far
    logic [CW-1:0] idle_q, idle_d;        // consecutive cycles without a byte

    logic          rdy_w;
    logic          accept_w;
    logic [15:0]   len_full_w;
    logic [15:0]   cap_inc_w;

    // Byte handshake is only open while the length or data is being received.
    always_comb begin
        rdy_w = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) || (state_q == ST_DATA);
    end

    assign accept_w   = rx_valid && rdy_w;
    assign len_full_w = {len_q[15:8], rx_data};
    assign cap_inc_w  = cap_q + 16'd1;

    // Next-state logic: framing, word assembly, write scheduling and timeout.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        words_d    = words_q;
        cap_d      = cap_q;
        idle_d     = idle_q;

        // The write counter advances at the end of every write cycle, which
        // keeps im_addr pointing at the word being written during the strobe.
        if (we_q) begin
            words_d = words_q + 16'd1;
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_LEN_HI;
                    words_d    = 16'd0;
                    cap_d      = 16'd0;
                    idle_d     = '0;
                    byte_idx_d = 2'd0;
                end
            end

            ST_LEN_HI: begin
                if (accept_w) begin
                    len_d[15:8] = rx_data;
                    state_d     = ST_LEN_LO;
                end
            end

            ST_LEN_LO: begin
                if (accept_w) begin
                    len_d      = len_full_w;
                    byte_idx_d = 2'd0;
                    if ((len_full_w == 16'd0) || ({1'b0, len_full_w} > MAX_WORDS_C)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (accept_w) begin
                    if (byte_idx_q == 2'd3) begin
                        // Word complete: present it and strobe on the next cycle.
                        wdata_d    = {shift_q, rx_data};
                        we_d       = 1'b1;
                        byte_idx_d = 2'd0;
                        cap_d      = cap_inc_w;
                        if (cap_inc_w == len_q) begin
                            state_d = ST_FLUSH;
                        end
                    end else begin
                        shift_d    = {shift_q[15:0], rx_data};
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end

            ST_FLUSH: begin
                // The final word's strobe is active during this cycle.
                state_d = ST_DONE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stall detection while the loader is waiting for bytes. A partial
        // word held in the shift register is simply abandoned on timeout.
        if (rdy_w) begin
            if (accept_w) begin
                idle_d = '0;
            end else begin
                idle_d = idle_q + 1'b1;
                if (idle_d == TIMEOUT_C) begin
                    state_d = ST_ERR;
                end
            end
        end
    end

    // State registers with synchronous reset; reset abandons any load in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= 16'd0;
            byte_idx_q <= 2'd0;
            shift_q    <= 24'd0;
            wdata_q    <= 32'd0;
            we_q       <= 1'b0;
            words_q    <= 16'd0;
            cap_q      <= 16'd0;
            idle_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            words_q    <= words_d;
            cap_q      <= cap_d;
            idle_q     <= idle_d;
        end
    end

    // Status outputs decode directly from the state; the core is released only in DONE.
    always_comb begin
        rx_ready     = rdy_w;
        loading      = rdy_w || (state_q == ST_FLUSH);
        done         = (state_q == ST_DONE);
        err          = (state_q == ST_ERR);
        cpu_rst_f    = (state_q == ST_DONE);
        im_we        = we_q;
        im_addr      = BASE_ADDR + words_q;
        im_wdata     = wdata_q;
        words_loaded = words_q;
    end

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed test of the program loader against a stream-level
// model (expected writes derived from the byte stream, expected status from
// the length rules) plus literal checks that pin the model.
module tb_im_loader;

    localparam logic [15:0] BASE = 16'h0000;
    localparam int          MAXW = 1024;
    localparam int          TMO  = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        im_we;
    logic [15:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_rst_f;
    logic        loading;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    always #5 clk = ~clk;

    im_loader #(
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAXW),
        .TIMEOUT  (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .im_we       (im_we),
        .im_addr     (im_addr),
        .im_wdata    (im_wdata),
        .cpu_rst_f   (cpu_rst_f),
        .loading     (loading),
        .done        (done),
        .err         (err),
        .words_loaded(words_loaded)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    bit          checking = 1'b0;
    logic        prev_we  = 1'b0;
    logic        prev_cpu = 1'b0;

    logic [7:0]  stream[$];
    logic [15:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    bit          exp_ok;
    int          exp_words;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare: every strobe must match the next expected write,
    // and the status outputs must stay mutually consistent.
    always @(negedge clk) begin
        if (checking) begin
            if (im_we === 1'b1) begin
                n_writes++;
                $display("write addr=%h data=%h words_loaded=%0d", im_addr, im_wdata, words_loaded);
                if (exp_addr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write", im_addr, im_wdata);
                end else begin
                    chk("write_addr", im_addr, exp_addr_q.pop_front());
                    chk("write_data", im_wdata, exp_data_q.pop_front());
                end
            end
            chk("cpu_rst_eq_done", cpu_rst_f, done);
            chk("ready_implies_loading", rx_ready & ~loading, 1'b0);
            chk("we_implies_loading", im_we & ~loading, 1'b0);
            chk("done_err_exclusive", done & err, 1'b0);
            chk("we_single_cycle", im_we & prev_we, 1'b0);
            if (cpu_rst_f && !prev_cpu) chk("cpu_release_after_write", prev_we, 1'b1);
            prev_we  <= im_we;
            prev_cpu <= cpu_rst_f;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offer one byte; within a load the loader must already be ready.
    task automatic send_byte(input logic [7:0] b);
        int w;
        w        = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        chk("rx_ready_on_offer", rx_ready, 1'b1);
        while (!rx_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Stream-level model: expected writes and final status from the bytes.
    task automatic model_expect();
        logic [15:0] n;
        int avail;
        exp_addr_q.delete();
        exp_data_q.delete();
        n         = {stream[0], stream[1]};
        exp_words = 0;
        if (n != 16'd0 && int'(n) <= MAXW) begin
            avail = (stream.size() - 2) / 4;
            for (int w = 0; w < int'(n) && w < avail; w++) begin
                exp_addr_q.push_back(BASE + 16'(w));
                exp_data_q.push_back({stream[2+4*w], stream[3+4*w], stream[4+4*w], stream[5+4*w]});
                exp_words++;
            end
        end
        exp_ok = (n != 16'd0) && (int'(n) <= MAXW) && (exp_words == int'(n));
    endtask

    task automatic load_stream(input int gap, input int start_at);
        model_expect();
        pulse_start();
        chk("start_holds_core", cpu_rst_f, 1'b0);
        chk("start_sets_loading", loading, 1'b1);
        chk("start_clears_count", words_loaded, 16'd0);
        foreach (stream[i]) begin
            send_byte(stream[i]);
            for (int g = 0; g < gap; g++) begin
                if (i == start_at && g == 0) start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
    endtask

    task automatic finish_check();
        int c;
        c = 0;
        @(negedge clk);
        while (!(done || err) && c < 2 * TMO + 100) begin
            @(negedge clk);
            c++;
        end
        if (!(done || err)) begin
            n_checks++;
            n_fail++;
            $display("FAIL load_end_timeout: got no done/err expected done or err within %0d cycles", 2 * TMO + 100);
        end
        chk("end_done", done, exp_ok);
        chk("end_err", err, !exp_ok);
        chk("end_cpu_rst_f", cpu_rst_f, exp_ok);
        chk("end_words_loaded", words_loaded, 16'(exp_words));
        chk("end_writes_pending", exp_addr_q.size(), 0);
        tick();
    endtask

    task automatic check_reset_values();
        chk("rst_rx_ready", rx_ready, 1'b0);
        chk("rst_im_we", im_we, 1'b0);
        chk("rst_im_addr", im_addr, BASE);
        chk("rst_im_wdata", im_wdata, 32'h0);
        chk("rst_cpu_rst_f", cpu_rst_f, 1'b0);
        chk("rst_loading", loading, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_words_loaded", words_loaded, 16'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        int cnt;
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) tick();
        check_reset_values();
        rst      = 1'b0;
        checking = 1'b1;
        tick();

        // Two words, continuous stream.
        w0 = n_writes;
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        load_stream(0, -1);
        finish_check();
        chk("s1_last_wdata", im_wdata, 32'h9ABCDEF0);
        chk("s1_write_count", n_writes - w0, 2);
        chk("s1_words_loaded", words_loaded, 16'd2);

        // Same stream with 5-cycle gaps.
        load_stream(5, -1);
        finish_check();

        // Illegal lengths.
        stream = '{8'h00, 8'h00};
        load_stream(0, -1);
        finish_check();
        chk("len0_err", err, 1'b1);
        stream = '{8'h04, 8'h01};
        load_stream(0, -1);
        finish_check();
        chk("lenmax1_err", err, 1'b1);

        // Timeout with a partial word.
        stream = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC};
        load_stream(0, -1);
        cnt = 0;
        @(negedge clk);
        while (!err && cnt < 2 * TMO) begin
            cnt++;
            @(negedge clk);
        end
        chk("timeout_cycles", cnt, TMO);
        finish_check();
        chk("timeout_words", words_loaded, 16'd0);
        stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        load_stream(0, -1);
        finish_check();
        chk("recover_wdata", im_wdata, 32'h11223344);

        // Start pulse inside DATA is ignored.
        stream = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        load_stream(1, 3);
        finish_check();
        chk("ignored_start_words", words_loaded, 16'd2);

        // Reset right after the first write of a 3-word load.
        stream = '{8'h00, 8'h03, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                   8'hC0, 8'hC1, 8'hC2, 8'hC3};
        model_expect();
        w0 = n_writes;
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(stream[i]);
        chk("pre_rst_writes", n_writes - w0, 1);
        rst = 1'b1;
        exp_addr_q.delete();
        exp_data_q.delete();
        tick();
        rst = 1'b0;
        check_reset_values();
        repeat (20) tick();
        chk("post_rst_writes", n_writes - w0, 1);

        // Back-to-back loads, second started from DONE.
        stream = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        load_stream(0, -1);
        finish_check();
        stream = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        load_stream(0, -1);
        finish_check();
        chk("b2b_wdata", im_wdata, 32'hCAFEBABE);
        chk("b2b_addr", im_addr, BASE + 16'd1);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
